i2c_byte_tx: RTL

I2C_BYTE_TX -- requirements
Module: i2c_byte_tx

---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_byte_tx.sv | 102 ++++++++++
 2 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C types and constants for the byte transmitter.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ACK    = 2'd2,
    FINISH = 2'd3
  } i2c_state_e;

  // Open-drain convention: 1 releases the line, 0 pulls it low.
  localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_byte_tx.sv
// I2C byte transmitter: shifts a NUM_BITS word out MSB first on SCL falls,
// then releases SDA and samples the slave ACK on the following SCL rise.
//
// state  | meaning
// IDLE   | line released, waiting for load
// SHIFT  | driving shift register MSB, shift on each scl_fall
// ACK    | line released, sample sda_in on scl_rise
// FINISH | line released, scl_fall ends the transfer with a done pulse
module i2c_byte_tx
  import i2c_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                scl_rise,
  input  logic                scl_fall,
  input  logic                sda_in,
  input  logic                abort,
  output logic                sda_out,
  output logic                busy,
  output logic                done,
  output logic                nack
);

  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  i2c_state_e          state_q, state_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                nack_q, nack_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_d = tx_data;
            cnt_d   = CNT_W'(NUM_BITS - 1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (scl_fall) begin
            if (cnt_q != '0) begin
              shift_d = shift_q << 1;
              cnt_d   = cnt_q - 1'b1;
            end else begin
              state_d = ACK;
            end
          end
        end
        ACK: begin
          // A coincident fall masks the rise, so no sample is taken.
          if (scl_rise && !scl_fall) begin
            nack_d  = sda_in;
            state_d = FINISH;
          end
        end
        FINISH: begin
          if (scl_fall) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_out = (state_q == SHIFT) ? shift_q[NUM_BITS-1] : SDA_RELEASE;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign nack    = nack_q;

endmodule
